// File: rtl/ppg_pkg.sv
// Shared definitions for the PPG peak detector: FSM state encoding and the
// default values of the detector parameters.
package ppg_pkg;

  localparam int          WIDTH_DEF   = 10;
  localparam int          THRESH_DEF  = 0;
  localparam int unsigned HYST_DEF    = 8;
  localparam int          CNT_W_DEF   = 12;
  localparam int          REFRACT_DEF = 20;

  // Peak search FSM: wait for arming, track the rising edge, then rest
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RISE    = 2'd1,
    ST_REFRACT = 2'd2
  } ppg_state_e;

endpackage

// File: rtl/ppg_sat_counter.sv
// Saturating up-counter used to measure the inter-beat interval in accepted
// samples. Clear takes priority over increment; the count sticks at all-ones.
module ppg_sat_counter #(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         saturate
);

  localparam logic [W-1:0] CNT_MAX = {W{1'b1}};

  // Count register: clear on confirm, otherwise bump on each accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {W{1'b0}};
    end else if (clr) begin
      cnt <= {W{1'b0}};
    end else if (inc && !saturate) begin
      cnt <= cnt + W'(1'b1);
    end else begin
      cnt <= cnt;
    end
  end

  assign saturate = (cnt == CNT_MAX);

endmodule

// File: rtl/ppg_peak_detector.sv
// PPG peak detector: arms when the decimated sample stream crosses THRESH,
// tracks the running maximum and confirms a beat once the signal has fallen
// HYST below it. Reports the peak amplitude and the inter-beat interval in
// accepted samples.
// Optional feature: define PPG_REFRACTORY_EN to add a refractory period of
// REFRACT accepted samples after each confirmed peak.
module ppg_peak_detector
  import ppg_pkg::*;
#(
  parameter int          Width   = WIDTH_DEF,
  parameter int          THRESH  = THRESH_DEF,
  parameter int unsigned HYST    = HYST_DEF,
  parameter int          CNT_W   = CNT_W_DEF,
  parameter int          REFRACT = REFRACT_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    valid_in,
  input  logic signed [Width-1:0] ppg_in,
  output logic                    beat_out,
  output logic signed [Width-1:0] peak_val,
  output logic [CNT_W-1:0]        ibi_out,
  output logic                    ibi_valid
);

  localparam logic signed [Width-1:0] THRESH_V = Width'(THRESH);
  localparam logic signed [Width:0]   HYST_V   = (Width+1)'(HYST);

  ppg_state_e              state_r;
  ppg_state_e              state_nxt_s;
  logic signed [Width-1:0] pk_r;
  logic signed [Width-1:0] pk_nxt_s;
  logic                    first_beat_r;
  logic                    accept_s;
  logic                    confirm_s;
  logic [CNT_W-1:0]        cnt_s;
  logic                    cnt_sat_s;
  // One extra bit so pk_r - HYST can never wrap around
  logic signed [Width:0]   in_ext_s;
  logic signed [Width:0]   drop_lvl_s;

`ifdef PPG_REFRACTORY_EN
  localparam int RF_W = (REFRACT > 1) ? $clog2(REFRACT) : 1;
  localparam logic [RF_W-1:0] REFR_LOAD = RF_W'(REFRACT - 1);

  logic [RF_W-1:0] refr_r;
  logic [RF_W-1:0] refr_nxt_s;
`else
  // Without the refractory state REFRACT has no effect; only its range is looked at
  if (REFRACT < 1) begin : g_refract_out_of_range
  end
`endif

  assign accept_s   = en & valid_in;
  assign in_ext_s   = {ppg_in[Width-1], ppg_in};
  assign drop_lvl_s = {pk_r[Width-1], pk_r} - HYST_V;

  // Next-state and peak tracking; everything moves only on accepted samples
  always_comb begin
    state_nxt_s = state_r;
    pk_nxt_s    = pk_r;
    confirm_s   = 1'b0;
`ifdef PPG_REFRACTORY_EN
    refr_nxt_s  = refr_r;
`endif
    if (accept_s) begin
      case (state_r)
        ST_IDLE: begin
          if (ppg_in > THRESH_V) begin
            state_nxt_s = ST_RISE;
            pk_nxt_s    = ppg_in;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_RISE: begin
          if (ppg_in >= pk_r) begin
            pk_nxt_s = ppg_in;
          end else if (in_ext_s <= drop_lvl_s) begin
            confirm_s = 1'b1;
`ifdef PPG_REFRACTORY_EN
            state_nxt_s = ST_REFRACT;
            refr_nxt_s  = REFR_LOAD;
`else
            state_nxt_s = ST_IDLE;
`endif
          end else begin
            state_nxt_s = ST_RISE;
          end
        end
        ST_REFRACT: begin
`ifdef PPG_REFRACTORY_EN
          if (refr_r == {RF_W{1'b0}}) begin
            state_nxt_s = ST_IDLE;
          end else begin
            refr_nxt_s = refr_r - RF_W'(1'b1);
          end
`else
          state_nxt_s = ST_IDLE;
`endif
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // State, running maximum and registered beat/IBI outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      pk_r         <= {Width{1'b0}};
      first_beat_r <= 1'b1;
      beat_out     <= 1'b0;
      peak_val     <= {Width{1'b0}};
      ibi_out      <= {CNT_W{1'b0}};
      ibi_valid    <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      pk_r     <= pk_nxt_s;
      beat_out <= confirm_s;
      if (confirm_s) begin
        peak_val <= pk_r;
        if (first_beat_r) begin
          // The first beat has no predecessor, so no interval to report
          first_beat_r <= 1'b0;
          ibi_valid    <= 1'b0;
        end else begin
          ibi_out   <= cnt_sat_s ? cnt_s : (cnt_s + CNT_W'(1'b1));
          ibi_valid <= 1'b1;
        end
      end else begin
        ibi_valid <= 1'b0;
      end
    end
  end

`ifdef PPG_REFRACTORY_EN
  // Refractory down-counter, loaded on confirm and stepped per accepted sample
  always_ff @(posedge clk) begin
    if (rst) begin
      refr_r <= {RF_W{1'b0}};
    end else begin
      refr_r <= refr_nxt_s;
    end
  end
`endif

  ppg_sat_counter #(
    .W(CNT_W)
  ) u_ibi_cnt (
    .clk      (clk),
    .rst      (rst),
    .inc      (accept_s),
    .clr      (confirm_s),
    .cnt      (cnt_s),
    .saturate (cnt_sat_s)
  );

endmodule

// File: tb/tb_ppg_peak_detector.sv
// Self-checking bench for ppg_peak_detector (CNT_W reduced to 6 so the
// saturation case is reachable). Expected outputs are queued when a cycle is
// driven and compared just after the following clock edge.
module tb_ppg_peak_detector;

  localparam int W  = 10;
  localparam int CW = 6;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                en = 1'b0;
  logic                valid_in = 1'b0;
  logic signed [W-1:0] ppg_in = '0;
  logic                beat_out;
  logic signed [W-1:0] peak_val;
  logic [CW-1:0]       ibi_out;
  logic                ibi_valid;

  typedef struct {
    logic beat;
    int   peak;
    int   ibi;
    logic ibiv;
  } exp_t;

  typedef struct {
    logic r;
    logic e;
    logic v;
    int   x;
    logic beat;
    int   peak;
    int   ibi;
    logic ibiv;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[9];
  int   checks = 0;
  int   errors = 0;
  int   step = 0;
  int   exp_peak = 0;
  int   exp_ibi = 0;

  always #5 clk = ~clk;

  ppg_peak_detector #(
    .CNT_W(CW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .valid_in  (valid_in),
    .ppg_in    (ppg_in),
    .beat_out  (beat_out),
    .peak_val  (peak_val),
    .ibi_out   (ibi_out),
    .ibi_valid (ibi_valid)
  );

  task automatic check1(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL step %0d %s: got %0d expected %0d", step, name, got, want);
    end
  endtask

  // Scoreboard: compare outputs against the record queued for this edge
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      step++;
      check1("beat_out", int'(beat_out), int'(e.beat));
      check1("peak_val", int'(peak_val), e.peak);
      check1("ibi_out", int'(ibi_out), e.ibi);
      check1("ibi_valid", int'(ibi_valid), int'(e.ibiv));
    end
  end

  task automatic drive(input logic r, input logic e, input logic v, input int x,
                       input logic b, input logic iv);
    exp_t s;
    @(negedge clk);
    rst      = r;
    en       = e;
    valid_in = v;
    ppg_in   = W'(x);
    s.beat   = b;
    s.peak   = exp_peak;
    s.ibi    = exp_ibi;
    s.ibiv   = iv;
    sb_q.push_back(s);
  endtask

  // One accepted sample; pk/ibi become the held expectations when pulsed
  task automatic acc(input int x, input logic b, input int pk, input logic iv, input int ibi);
    if (b) exp_peak = pk;
    if (iv) exp_ibi = ibi;
    drive(1'b0, 1'b1, 1'b1, x, b, iv);
  endtask

  task automatic gap(input logic e, input logic v, input int x);
    drive(1'b0, e, v, x, 1'b0, 1'b0);
  endtask

  task automatic rst_cycle(input int x);
    exp_peak = 0;
    exp_ibi  = 0;
    drive(1'b1, 1'b1, 1'b1, x, 1'b0, 1'b0);
  endtask

  task automatic gaps_after(input logic gaps, input int idx);
    if (gaps) begin
      repeat (3) gap(1'b1, 1'b0, 300);
      if (idx == 20) repeat (5) gap(1'b0, 1'b1, 300);
    end
  endtask

  // lead non-arming samples, then amp/2, amp, amp, amp-7, amp-8 (confirm)
  task automatic triangle(input int lead, input int amp, input logic gaps,
                          input logic b, input int ibi, input logic iv);
    int vals[4];
    vals[0] = amp / 2;
    vals[1] = amp;
    vals[2] = amp;
    vals[3] = amp - 7;
    for (int i = 0; i < lead; i++) begin
      acc(((i % 2) != 0) ? -30 : 0, 1'b0, 0, 1'b0, 0);
      gaps_after(gaps, i);
    end
    for (int i = 0; i < 4; i++) begin
      acc(vals[i], 1'b0, 0, 1'b0, 0);
      gaps_after(gaps, lead + i);
    end
    acc(amp - 8, b, amp, iv, ibi);
    gaps_after(gaps, lead + 4);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) acc(0, 1'b0, 0, 1'b0, 0);
  endtask

  initial begin
    // Reset with live inputs, then the first peak (en=0 sample must be ignored)
    tbl[0] = '{1'b1, 1'b1, 1'b1, 100, 1'b0, 0, 0, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 100, 1'b0, 0, 0, 1'b0};
    tbl[2] = '{1'b0, 1'b1, 1'b1, 0,   1'b0, 0, 0, 1'b0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 10,  1'b0, 0, 0, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 500, 1'b0, 0, 0, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 50,  1'b0, 0, 0, 1'b0};
    tbl[6] = '{1'b0, 1'b1, 1'b1, 100, 1'b0, 0, 0, 1'b0};
    tbl[7] = '{1'b0, 1'b1, 1'b1, 90,  1'b1, 100, 0, 1'b0};
    tbl[8] = '{1'b0, 1'b1, 1'b0, 0,   1'b0, 100, 0, 1'b0};

    for (int i = 0; i < 9; i++) begin
      exp_peak = tbl[i].peak;
      exp_ibi  = tbl[i].ibi;
      drive(tbl[i].r, tbl[i].e, tbl[i].v, tbl[i].x, tbl[i].beat, tbl[i].ibiv);
    end

    // Second beat 40 accepted samples after the first
    triangle(35, 100, 1'b0, 1'b1, 40, 1'b1);

    // Same interval with valid_in gaps and an en=0 window
    triangle(35, 120, 1'b1, 1'b1, 40, 1'b1);

    // Peak 10 samples after the previous confirm
`ifdef PPG_REFRACTORY_EN
    triangle(5, 100, 1'b0, 1'b0, 0, 1'b0);
`else
    triangle(5, 100, 1'b0, 1'b1, 10, 1'b1);
`endif
    quiet(25);

    // 100 samples between confirms overflows a 6-bit interval
    triangle(70, 500, 1'b0, 1'b1, 63, 1'b1);
    quiet(25);

    // Reset while rising at pk=80: pending peak is dropped, FSM back to IDLE
    acc(40, 1'b0, 0, 1'b0, 0);
    acc(80, 1'b0, 0, 1'b0, 0);
    rst_cycle(0);
    acc(70, 1'b0, 0, 1'b0, 0);
    acc(62, 1'b1, 70, 1'b0, 0);
    gap(1'b1, 1'b0, 0);

    repeat (2) @(posedge clk);
    #2;
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
